// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (instruction fetch / load-store) arbiter in front of
// a DDR3 user interface. One transaction is outstanding at a time. All DDR3
// strobes, done pulses and busy are registered from the next-state values, so
// each of them is high for exactly the cycles the FSM spends in the state that
// drives it.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Without it, the data port always wins a tie.
module memory_arbiter #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // load/store port
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_done_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  // DDR3 command side
  output logic              memory_enable_o,
  output logic              memory_cmd_o,
  output logic [ADDR_W-1:0] memory_address_o,
  input  logic              memory_cmd_rdy_i,
  // DDR3 write side
  output logic              memory_write_enable_o,
  output logic [DATA_W-1:0] memory_write_data_o,
  output logic              memory_write_data_end_o,
  input  logic              memory_write_rdy_i,
  // DDR3 read side
  input  logic [DATA_W-1:0] memory_read_data_i,
  input  logic              memory_read_data_valid_i,
  input  logic              memory_read_data_end_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    CMD   = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic                owner_fetch_q, owner_fetch_n;  // 1: fetch port owns the transaction
  logic                we_q, we_n;
  logic                got_q, got_n;                  // first read beat already captured
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                grant_fetch;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_fetch_q;                  // 1: fetch port was granted last

  // On a tie the port that was not granted last wins.
  assign grant_fetch = if_req_i && (!ls_req_i || !last_fetch_q);

  // Last-grant pointer, updated on every grant; starts at the data port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fetch_q <= 1'b0;
    end else if (state_q == IDLE && (if_req_i || ls_req_i)) begin
      last_fetch_q <= grant_fetch;
    end
  end
`else
  // Fixed priority: the data port wins every tie.
  assign grant_fetch = if_req_i && !ls_req_i;
`endif

  // Next-state and next-value logic for the transaction FSM.
  always_comb begin
    state_n       = state_q;
    owner_fetch_n = owner_fetch_q;
    we_n          = we_q;
    got_n         = got_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    rdata_n       = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_req_i || ls_req_i) begin
          owner_fetch_n = grant_fetch;
          // fetches are always reads, whatever ls_we_i says
          we_n          = !grant_fetch && ls_we_i;
          addr_n        = grant_fetch ? if_addr_i : ls_addr_i;
          wdata_n       = ls_wdata_i;
          state_n       = (!grant_fetch && ls_we_i) ? WDATA : CMD;
        end
      end
      WDATA: begin
        if (memory_write_rdy_i) state_n = CMD;
      end
      CMD: begin
        if (memory_cmd_rdy_i) begin
          if (we_q) begin
            state_n = DONE;
          end else begin
            state_n = RWAIT;
            got_n   = 1'b0;
          end
        end
      end
      RWAIT: begin
        if (memory_read_data_valid_i && !got_q) begin
          rdata_n = memory_read_data_i;
          got_n   = 1'b1;
        end
        if (memory_read_data_valid_i && memory_read_data_end_i) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= IDLE;
      owner_fetch_q           <= 1'b0;
      we_q                    <= 1'b0;
      got_q                   <= 1'b0;
      if_done_o               <= 1'b0;
      ls_done_o               <= 1'b0;
      if_rdata_o              <= '0;
      ls_rdata_o              <= '0;
      memory_enable_o         <= 1'b0;
      memory_cmd_o            <= 1'b0;
      memory_address_o        <= '0;
      memory_write_enable_o   <= 1'b0;
      memory_write_data_o     <= '0;
      memory_write_data_end_o <= 1'b0;
      busy_o                  <= 1'b0;
    end else begin
      state_q                 <= state_n;
      owner_fetch_q           <= owner_fetch_n;
      we_q                    <= we_n;
      got_q                   <= got_n;
      if_done_o               <= (state_n == DONE) && owner_fetch_n;
      ls_done_o               <= (state_n == DONE) && !owner_fetch_n;
      memory_enable_o         <= (state_n == CMD);
      memory_cmd_o            <= (state_n == CMD) && we_n;
      memory_address_o        <= (state_n == CMD) ? addr_n : '0;
      memory_write_enable_o   <= (state_n == WDATA);
      memory_write_data_o     <= (state_n == WDATA) ? wdata_n : '0;
      memory_write_data_end_o <= (state_n == WDATA);
      busy_o                  <= (state_n != IDLE);
      // read data is published on entry to DONE and held until the next read
      if (state_q == RWAIT && state_n == DONE) begin
        if (owner_fetch_q) if_rdata_o <= rdata_n;
        else               ls_rdata_o <= rdata_n;
      end
    end
  end

  // Transaction payload; only meaningful while the FSM owns a transaction.
  always_ff @(posedge clk) begin
    addr_q  <= addr_n;
    wdata_q <= wdata_n;
    rdata_q <= rdata_n;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: random requesters on both ports and a random DDR3 model
// (ready stalls, 1-3 read beats, stray beats and stray end flags), checked
// against a transaction-level reference of the arbiter. One asynchronous reset
// pulse is injected while a read waits for data.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [28:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [28:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_done_o;
  logic [31:0] ls_rdata_o;
  logic        memory_enable_o;
  logic        memory_cmd_o;
  logic [28:0] memory_address_o;
  logic        memory_cmd_rdy_i;
  logic        memory_write_enable_o;
  logic [31:0] memory_write_data_o;
  logic        memory_write_data_end_o;
  logic        memory_write_rdy_i;
  logic [31:0] memory_read_data_i;
  logic        memory_read_data_valid_i;
  logic        memory_read_data_end_i;
  logic        busy_o;

  memory_arbiter dut (
    .clk                      (clk),
    .rst                      (rst),
    .if_req_i                 (if_req_i),
    .if_addr_i                (if_addr_i),
    .if_done_o                (if_done_o),
    .if_rdata_o               (if_rdata_o),
    .ls_req_i                 (ls_req_i),
    .ls_we_i                  (ls_we_i),
    .ls_addr_i                (ls_addr_i),
    .ls_wdata_i               (ls_wdata_i),
    .ls_done_o                (ls_done_o),
    .ls_rdata_o               (ls_rdata_o),
    .memory_enable_o          (memory_enable_o),
    .memory_cmd_o             (memory_cmd_o),
    .memory_address_o         (memory_address_o),
    .memory_cmd_rdy_i         (memory_cmd_rdy_i),
    .memory_write_enable_o    (memory_write_enable_o),
    .memory_write_data_o      (memory_write_data_o),
    .memory_write_data_end_o  (memory_write_data_end_o),
    .memory_write_rdy_i       (memory_write_rdy_i),
    .memory_read_data_i       (memory_read_data_i),
    .memory_read_data_valid_i (memory_read_data_valid_i),
    .memory_read_data_end_i   (memory_read_data_end_i),
    .busy_o                   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_if;
    bit          we;
    logic [28:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          n_tests = 0;
  int          n_fail  = 0;

  // reference model state
  txn_t        cur;
  bit          cur_valid      = 1'b0;
  bit          read_phase     = 1'b0;
  bit          accept_pending = 1'b0;
  bit          end_pending    = 1'b0;
  bit          first_seen     = 1'b0;
  bit          busy_prev      = 1'b0;
  bit          last_if        = 1'b0;
  bit          slow           = 1'b0;
  bit          rst_injected   = 1'b0;
  logic [31:0] first_data     = '0;
  logic [31:0] exp_if_rdata   = '0;
  logic [31:0] exp_ls_rdata   = '0;
  int          beats          = 0;
  int          age            = 0;
  int          reads_done     = 0;
  int          writes_done    = 0;
  int          ties           = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule: data port wins ties, or alternate when round-robin is built in.
  function automatic bit pick_if(input bit ifr, input bit lsr);
`ifdef ARB_ROUND_ROBIN_EN
    if (ifr && lsr) return !last_if;
`endif
    return ifr && !lsr;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_if_done"},  32'(if_done_o), 32'd0);
    check({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    check({tag, "_ls_done"},  32'(ls_done_o), 32'd0);
    check({tag, "_ls_rdata"}, ls_rdata_o, 32'd0);
    check({tag, "_en"},       32'(memory_enable_o), 32'd0);
    check({tag, "_cmd"},      32'(memory_cmd_o), 32'd0);
    check({tag, "_addr"},     32'(memory_address_o), 32'd0);
    check({tag, "_wen"},      32'(memory_write_enable_o), 32'd0);
    check({tag, "_wdata"},    memory_write_data_o, 32'd0);
    check({tag, "_wend"},     32'(memory_write_data_end_o), 32'd0);
    check({tag, "_busy"},     32'(busy_o), 32'd0);
  endtask

  // One cycle of the bench, run at the falling edge.
  task automatic step();
    bit done_now;
    bit win_if;
    done_now = 1'b0;

    // what happened at the rising edge just passed
    if (accept_pending) begin
      accept_pending = 1'b0;
      if (cur.we) begin
        done_now = 1'b1;
      end else begin
        read_phase = 1'b1;
        first_seen = 1'b0;
        beats      = 0;
      end
    end
    if (end_pending) begin
      end_pending = 1'b0;
      read_phase  = 1'b0;
      done_now    = 1'b1;
    end

    // a new grant shows up as busy rising; requests were sampled at that edge
    if (busy_o && !busy_prev) begin
      check("grant_has_req", 32'(if_req_i || ls_req_i), 32'd1);
      check("single_txn", 32'(cur_valid), 32'd0);
      if (if_req_i && ls_req_i) ties++;
      win_if      = pick_if(if_req_i, ls_req_i);
      last_if     = win_if;
      cur.port_if = win_if;
      cur.we      = !win_if && ls_we_i;
      cur.addr    = win_if ? if_addr_i : ls_addr_i;
      cur.wdata   = ls_wdata_i;
      cur_valid   = 1'b1;
      age         = 0;
      slow        = ($urandom_range(0, 3) == 0);
    end
    busy_prev = busy_o;

    if (cur_valid) begin
      check("busy_active", 32'(busy_o), 32'd1);
      age++;
      if (age > 400) begin
        check("txn_timeout", 32'(age), 32'd400);
        cur_valid  = 1'b0;
        read_phase = 1'b0;
      end
    end else begin
      check("busy_idle", 32'(busy_o), 32'd0);
    end

    check("if_done", 32'(if_done_o), 32'(done_now && cur.port_if));
    check("ls_done", 32'(ls_done_o), 32'(done_now && !cur.port_if));
    if (done_now) begin
      if (!cur.we) begin
        if (cur.port_if) exp_if_rdata = first_data;
        else             exp_ls_rdata = first_data;
        reads_done++;
      end else begin
        writes_done++;
      end
      check("done_strobes", 32'({memory_enable_o, memory_write_enable_o, memory_write_data_end_o}), 32'd0);
      if (cur.port_if) if_req_i = 1'b0;
      else             ls_req_i = 1'b0;
      cur_valid = 1'b0;
    end
    check("if_rdata", if_rdata_o, exp_if_rdata);
    check("ls_rdata", ls_rdata_o, exp_ls_rdata);

    if (memory_write_enable_o) begin
      check("wr_owner", 32'(cur_valid && cur.we), 32'd1);
      check("wr_data", memory_write_data_o, cur.wdata);
      check("wr_end", 32'(memory_write_data_end_o), 32'd1);
      check("wr_no_cmd", 32'(memory_enable_o), 32'd0);
    end
    if (memory_enable_o) begin
      check("cmd_owner", 32'(cur_valid), 32'd1);
      check("cmd_we", 32'(memory_cmd_o), 32'(cur.we));
      check("cmd_addr", 32'(memory_address_o), 32'(cur.addr));
    end
    if (read_phase || !busy_o)
      check("strobes_quiet", 32'({memory_enable_o, memory_write_enable_o, memory_write_data_end_o}), 32'd0);

    // DDR3 model drive for the next rising edge
    memory_write_rdy_i = slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
    memory_cmd_rdy_i   = slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
    accept_pending     = cur_valid && memory_enable_o && memory_cmd_rdy_i;
    memory_read_data_i = $urandom;
    if (read_phase) begin
      memory_read_data_valid_i = ($urandom_range(0, 2) != 0);
      if (memory_read_data_valid_i) begin
        if (!first_seen) begin
          first_data = memory_read_data_i;
          first_seen = 1'b1;
        end
        beats++;
        memory_read_data_end_i = (beats >= 3) || ($urandom_range(0, 1) == 1);
        end_pending            = memory_read_data_end_i;
      end else begin
        memory_read_data_end_i = 1'($urandom_range(0, 1));
      end
    end else begin
      // beats outside a read wait must be ignored
      memory_read_data_valid_i = ($urandom_range(0, 7) == 0);
      memory_read_data_end_i   = 1'($urandom_range(0, 1));
    end

    // requesters: a request is held with stable payload until its done pulse
    if (!if_req_i && $urandom_range(0, 2) == 0) begin
      if_req_i  = 1'b1;
      if_addr_i = 29'($urandom);
    end
    if (!ls_req_i && $urandom_range(0, 2) == 0) begin
      ls_req_i   = 1'b1;
      ls_we_i    = 1'($urandom_range(0, 1));
      ls_addr_i  = 29'($urandom);
      ls_wdata_i = $urandom;
    end
  endtask

  initial begin
    rst                      = 1'b1;
    if_req_i                 = 1'b0;
    if_addr_i                = '0;
    ls_req_i                 = 1'b0;
    ls_we_i                  = 1'b0;
    ls_addr_i                = '0;
    ls_wdata_i               = '0;
    memory_cmd_rdy_i         = 1'b0;
    memory_write_rdy_i       = 1'b0;
    memory_read_data_i       = '0;
    memory_read_data_valid_i = 1'b0;
    memory_read_data_end_i   = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      step();
      if (!rst_injected && cyc > 300 && read_phase) begin
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        #1 rst = 1'b0;
        rst_injected             = 1'b1;
        cur_valid                = 1'b0;
        read_phase               = 1'b0;
        accept_pending           = 1'b0;
        end_pending              = 1'b0;
        busy_prev                = 1'b0;
        last_if                  = 1'b0;
        exp_if_rdata             = '0;
        exp_ls_rdata             = '0;
        memory_read_data_valid_i = 1'b0;
      end
    end

    check("rst_injected", 32'(rst_injected), 32'd1);
    check("reads_seen", 32'(reads_done > 20), 32'd1);
    check("writes_seen", 32'(writes_done > 20), 32'd1);
    check("ties_seen", 32'(ties > 5), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
